// File: rtl/us_ctrl_pkg.sv
// us_ctrl_pkg: shared definitions for the ultrasound shot scheduler.
//   - command byte codes accepted from the UART receiver
//   - ACK/NAK response bytes and a helper that builds an ACK from a command
//   - shot sequencer FSM state encoding
package us_ctrl_pkg;

    localparam logic [7:0] CMD_SINGLE = 8'h01;
    localparam logic [7:0] CMD_CONT   = 8'h02;
    localparam logic [7:0] CMD_STOP   = 8'h04;

    localparam logic [7:0] ACK_BASE   = 8'hA0;
    localparam logic [7:0] NAK        = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BURST  = 3'd1,
        ST_BLANK  = 3'd2,
        ST_LISTEN = 3'd3,
        ST_GAP    = 3'd4
    } shot_state_t;

    // ACK carries the low nibble of the command it acknowledges.
    function automatic logic [7:0] ack_byte(input logic [7:0] cmd);
        return ACK_BASE | {4'h0, cmd[3:0]};
    endfunction

endpackage

// File: rtl/us_tof_capture.sv
// us_tof_capture: time-of-flight measurement for one shot.
//   clk_50M    system clock
//   rst        synchronous active-high reset
//   clear      pulse on the cycle before the first BURST cycle; counter reads 0 in that first cycle
//   arm        high while listening; only echo edges seen while armed are captured
//   done       high on the last listen cycle; tof/tof_valid update on the following cycle
//   echo_in    asynchronous comparator output
//   tof        last measured TOF in cycles (all-ones when no echo was seen)
//   tof_valid  one-cycle strobe when tof is updated
module us_tof_capture #(
    parameter int TOF_W = 24
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic             clear,
    input  logic             arm,
    input  logic             done,
    input  logic             echo_in,
    output logic [TOF_W-1:0] tof,
    output logic             tof_valid
);

    localparam logic [TOF_W-1:0] ALL_ONES = '1;

    logic             sync1;
    logic             sync2;
    logic             sync2_d;
    logic             rise;
    logic             seen;
    logic [TOF_W-1:0] cnt;
    logic [TOF_W-1:0] latched;

    // Edge detect on the synchronized echo; the two sync stages are part of
    // the reported TOF and are deliberately not subtracted.
    assign rise = sync2 & ~sync2_d;

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync2_d   <= 1'b0;
            seen      <= 1'b0;
            cnt       <= '0;
            latched   <= '0;
            tof       <= '0;
            tof_valid <= 1'b0;
        end else begin
            sync1     <= echo_in;
            sync2     <= sync1;
            sync2_d   <= sync2;
            tof_valid <= 1'b0;

            if (clear) begin
                cnt  <= '0;
                seen <= 1'b0;
            end else begin
                if (cnt != ALL_ONES) begin
                    cnt <= cnt + 1'b1;
                end
                if (arm && rise && !seen) begin
                    latched <= cnt;
                    seen    <= 1'b1;
                end
            end

            // An edge on the very last listen cycle still counts.
            if (done) begin
                tof_valid <= 1'b1;
                if (seen) begin
                    tof <= latched;
                end else if (arm && rise) begin
                    tof <= cnt;
                end else begin
                    tof <= ALL_ONES;
                end
            end
        end
    end

endmodule

// File: rtl/us_shot_scheduler.sv
// us_shot_scheduler: command-driven ultrasonic shot sequencer.
//   clk_50M, rst          clock, synchronous active-high reset
//   rx_done, rx_data      command byte strobe from the UART receiver
//   echo_in               asynchronous echo comparator
//   tx_busy               UART transmitter busy
//   tx_start, tx_data     ACK/NAK byte to the UART transmitter
//   us_drv                transducer drive square wave (BURST only)
//   listen_en             high throughout LISTEN
//   busy                  high whenever the sequencer is not IDLE
//   tof, tof_valid        time-of-flight result, strobed at LISTEN exit
// Each shot: BURST -> BLANK -> LISTEN, then IDLE, or GAP/BURST when repeating.
// The FSM state register "state" is the observable sequencer state.
module us_shot_scheduler
    import us_ctrl_pkg::*;
#(
    parameter int HALF_CYC   = 625,
    parameter int BURST_N    = 8,
    parameter int BLANK_CYC  = 5000,
    parameter int LISTEN_CYC = 1_500_000,
    parameter int PERIOD_CYC = 2_500_000,
    parameter int TOF_W      = 24
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic             rx_done,
    input  logic [7:0]       rx_data,
    input  logic             echo_in,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             us_drv,
    output logic             listen_en,
    output logic             busy,
    output logic [TOF_W-1:0] tof,
    output logic             tof_valid
);

    localparam int          BURST_LEN   = 2 * HALF_CYC * BURST_N;
    localparam logic [31:0] HALF_LAST   = 32'(HALF_CYC - 1);
    localparam logic [31:0] BURST_LAST  = 32'(BURST_LEN - 1);
    localparam logic [31:0] BLANK_LAST  = 32'(BLANK_CYC - 1);
    localparam logic [31:0] LISTEN_LAST = 32'(LISTEN_CYC - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYC - 1);
    // When the period is no longer than one shot, the next burst follows LISTEN directly.
    localparam bit          SKIP_GAP    = (PERIOD_CYC <= BURST_LEN + BLANK_CYC + LISTEN_CYC);

    shot_state_t state;
    logic [31:0] cnt;         // cycles spent in the current state
    logic [31:0] half_cnt;    // cycles in the current drive half period
    logic [31:0] period_cnt;  // cycles since the first BURST cycle of this shot
    logic        cont;
    logic        pend;
    logic [7:0]  pend_data;

    logic        is_single;
    logic        is_cont;
    logic        is_stop;
    logic        listen_last;
    logic        repeat_shot;
    logic        start_now;
    logic        shot_done;
    logic [7:0]  resp_byte;

    always_comb begin
        is_single   = rx_done && (rx_data == CMD_SINGLE);
        is_cont     = rx_done && (rx_data == CMD_CONT);
        is_stop     = rx_done && (rx_data == CMD_STOP);
        listen_last = (state == ST_LISTEN) && (cnt == LISTEN_LAST);
        // A CONT landing on the last listen cycle already counts for this exit.
        repeat_shot = cont || is_cont;
        start_now   = !is_stop &&
                      (((state == ST_IDLE) && (is_single || is_cont)) ||
                       ((state == ST_GAP) && (period_cnt == PERIOD_LAST)) ||
                       (listen_last && repeat_shot && SKIP_GAP));
        // STOP on the last listen cycle suppresses the result.
        shot_done   = listen_last && !is_stop;
        resp_byte   = NAK;
        if (is_stop || is_cont || (is_single && (state == ST_IDLE))) begin
            resp_byte = ack_byte(rx_data);
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            half_cnt   <= '0;
            period_cnt <= '0;
            cont       <= 1'b0;
            us_drv     <= 1'b0;
            listen_en  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cnt <= cnt + 32'd1;
            if (start_now || is_stop) begin
                period_cnt <= '0;
            end else if (state != ST_IDLE) begin
                period_cnt <= period_cnt + 32'd1;
            end
            if (is_cont) begin
                cont <= 1'b1;
            end

            if (is_stop) begin
                state     <= ST_IDLE;
                cont      <= 1'b0;
                cnt       <= '0;
                us_drv    <= 1'b0;
                listen_en <= 1'b0;
                busy      <= 1'b0;
            end else if (start_now) begin
                state     <= ST_BURST;
                cnt       <= '0;
                half_cnt  <= '0;
                us_drv    <= 1'b1;
                listen_en <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    ST_BURST: begin
                        if (half_cnt == HALF_LAST) begin
                            half_cnt <= '0;
                            us_drv   <= ~us_drv;
                        end else begin
                            half_cnt <= half_cnt + 32'd1;
                        end
                        if (cnt == BURST_LAST) begin
                            state  <= ST_BLANK;
                            cnt    <= '0;
                            us_drv <= 1'b0;
                        end
                    end
                    ST_BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state     <= ST_LISTEN;
                            cnt       <= '0;
                            listen_en <= 1'b1;
                        end
                    end
                    ST_LISTEN: begin
                        if (listen_last) begin
                            cnt       <= '0;
                            listen_en <= 1'b0;
                            if (repeat_shot) begin
                                state <= ST_GAP;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ST_GAP: begin
                        cnt <= '0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Response handshake: a response fills a single pending slot (newest
    // overwrites an unsent one). tx_start is a one-cycle strobe issued the
    // cycle after the slot is pending and tx_busy was low; tx_data is loaded
    // with it and held until the next tx_start. No strobe is issued on the
    // cycle right after a strobe, giving the transmitter time to raise busy.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_data <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
        end else begin
            tx_start <= 1'b0;
            if (pend && !tx_busy && !tx_start) begin
                tx_start <= 1'b1;
                tx_data  <= pend_data;
                pend     <= 1'b0;
            end
            if (rx_done) begin
                pend      <= 1'b1;
                pend_data <= resp_byte;
            end
        end
    end

    us_tof_capture #(
        .TOF_W(TOF_W)
    ) u_tof (
        .clk_50M  (clk_50M),
        .rst      (rst),
        .clear    (start_now),
        .arm      (state == ST_LISTEN),
        .done     (shot_done),
        .echo_in  (echo_in),
        .tof      (tof),
        .tof_valid(tof_valid)
    );

endmodule

// File: doc/us_shot_scheduler.md
# us_shot_scheduler

Command-driven shot sequencer for the ultrasound front end. Consumes decoded bytes from the UART receiver and fires single or repeating ultrasonic shots. Each shot is a fixed sequence: transmit burst, ringdown blanking, then an echo listen window. Measures time-of-flight (TOF) to the first echo edge and reports ACK/NAK bytes to the UART transmitter through a start/busy handshake.

## Interface
Parameters:
- HALF_CYC, 625: clk cycles per half period of the drive square wave (40 kHz at 50 MHz).
- BURST_N, 8: drive pulses per shot.
- BLANK_CYC, 5000: ringdown blanking length in cycles (100 µs).
- LISTEN_CYC, 1_500_000: echo listen window length in cycles (30 ms).
- PERIOD_CYC, 2_500_000: shot-to-shot period in continuous mode, measured from the first BURST cycle.
- TOF_W, 24: TOF counter width.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst  in  1  reset; synchronous, active-high.
- rx_done  in  1  one-cycle strobe: rx_data is valid.
- rx_data  in  8  received command byte.
- echo_in  in  1  asynchronous echo comparator output.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle strobe: send tx_data.
- tx_data  out  8  ACK/NAK byte; held stable from tx_start until the next tx_start.
- us_drv  out  1  transducer drive square wave.
- listen_en  out  1  high throughout LISTEN.
- busy  out  1  high whenever the state is not IDLE.
- tof  out  TOF_W  last measured TOF in cycles.
- tof_valid  out  1  one-cycle strobe: tof updated.

## Operation
- Commands:
  - 0x01 SINGLE: one shot.
  - 0x02 CONT: repeating shots.
  - 0x04 STOP.
  - Any other byte: NAK 0xEE; state unchanged.
- ACK byte is 0xA0 | cmd[3:0], e.g. 0xA1, 0xA2, 0xA4.
- Command rules by current state:
  - SINGLE in IDLE: start shot, ACK. SINGLE while busy: NAK, no effect.
  - CONT in IDLE: start shots, set the cont flag, ACK. CONT while busy: set the cont flag, ACK; the current shot continues.
  - STOP in any state: immediately go to IDLE, clear the cont flag, force us_drv=0 and listen_en=0, ACK. No tof_valid is produced for the aborted shot.
- FSM states: IDLE, BURST, BLANK, LISTEN, GAP.
  - IDLE→BURST: on a start command.
  - BURST→BLANK: after 2·HALF_CYC·BURST_N cycles.
  - BLANK→LISTEN: after BLANK_CYC cycles.
  - LISTEN exit: after LISTEN_CYC cycles, go to GAP if cont is set, else IDLE.
  - GAP→BURST: when the period counter reaches PERIOD_CYC. If PERIOD_CYC ≤ burst+blank+listen, skip GAP and go directly LISTEN→BURST.
- us_drv:
  - High during the first HALF_CYC cycles of BURST, then toggles every HALF_CYC cycles.
  - Low in all other states.
- TOF:
  - The TOF counter clears on the first BURST cycle and increments every cycle, saturating at all-ones.
  - echo_in passes through a 2-FF synchronizer, then rising-edge detection.
  - The first rising edge seen during LISTEN latches the counter value. Edges outside LISTEN are ignored.
  - Synchronizer latency (2 cycles) is included in tof and is not compensated.
  - At LISTEN exit: tof_valid pulses; tof = the latched value, or all-ones if no echo was seen.
- ACK queue:
  - Single pending slot. A new response overwrites an unsent one (latest wins).
  - tx_start is issued when the slot is pending and tx_busy=0.

## Timing
- Reset values:
  - State IDLE; cont flag, period counter, TOF counter and pending slot cleared.
  - All outputs 0: tx_start, tx_data, us_drv, listen_en, busy, tof, tof_valid.
  - Synchronizer flops are reset to 0.
- Command latency: rx_done at cycle t → state, busy and us_drv updated at t+1 (first BURST cycle).
- ACK latency:
  - Pending slot set at t+1.
  - tx_start at t+2 at the earliest, i.e. the cycle after the slot is pending and tx_busy=0.
  - tx_start is never asserted while tx_busy=1.
- tof_valid coincides with the first cycle after LISTEN, whether that cycle is IDLE, GAP or BURST.
- Simultaneous events:
  - STOP arriving on the same cycle as the LISTEN exit: STOP wins and no tof_valid is produced.
  - rst overrides everything, including mid-shot and mid-handshake.

## Structure
- Shared package us_ctrl_pkg holds:
  - Command codes CMD_SINGLE, CMD_CONT, CMD_STOP.
  - ACK_BASE = 0xA0 and NAK = 0xEE.
  - The FSM state enum.
- Sub-module us_tof_capture contains the synchronizer, edge detect and saturating counter. It is controlled by clear, arm (= LISTEN) and done signals, and outputs tof/tof_valid.

## Test plan
Run with test-scale parameters: HALF_CYC=4, BURST_N=2, BLANK_CYC=10, LISTEN_CYC=50, PERIOD_CYC=100.
- SINGLE with an echo edge 30 cycles after burst start:
  - us_drv shows 2 pulses of 8 cycles each.
  - tof_valid with tof=32 (30 + 2 synchronizer cycles).
  - ACK 0xA1; return to IDLE.
- SINGLE with no echo: tof=0xFFFFFF at LISTEN exit.
- CONT, then STOP mid-BLANK of the 3rd shot:
  - Burst starts spaced exactly 100 cycles apart.
  - Immediate IDLE with us_drv=0; no 3rd tof_valid.
  - ACKs 0xA2 then 0xA4.
- Byte 0xFF, and SINGLE while busy: each produces NAK 0xEE with state unchanged.
- Two commands issued while tx_busy is held high: only the latest response is sent once tx_busy falls, with exactly one tx_start.
- rst asserted mid-BURST: all outputs are 0 on the next cycle.
